// File: rtl/student_fir_pkg.sv
// Shared types for the FIR coefficient read sequencer.
//   coeff_seq_state_e : sequencer FSM states
//   tap_bundle_t      : default FIFO entry (coefficient + tap metadata) at the
//                       default widths; the top builds an equivalent struct at
//                       its own parameter widths.
//   MinFifoDepth      : smallest output FIFO that sustains one tap per cycle
//                       (one entry being popped, one read in flight, one issuing).
package student_fir_pkg;

  localparam int MinFifoDepth   = 3;
  localparam int TapIdxWidth    = 10;
  localparam int TapCoeffWidth  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } coeff_seq_state_e;

  typedef struct packed {
    logic [TapCoeffWidth-1:0] coeff;
    logic [TapIdxWidth-1:0]   idx;
    logic                     first;
    logic                     last;
  } tap_bundle_t;

endpackage

// File: rtl/student_sync_fifo.sv
// Generic synchronous FIFO with synchronous active-high reset.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, flushes pointers and occupancy
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry (meaningful only when !empty_o)
//   occ_o        : number of stored entries
//   empty_o      : no entries stored
//   full_o       : Depth entries stored
module student_sync_fifo
  import student_fir_pkg::*;
#(
  parameter type entry_t = tap_bundle_t,
  parameter int  Depth   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  output entry_t                       head_o,
  output logic [$clog2(Depth+1)-1:0]   occ_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers decide what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCnt);

endmodule

// File: rtl/student_fir_coeff_sequencer.sv
// Read-side controller for the FIR coefficient DPRAM (port b). Each accepted
// sample starts a frame that reads coefficient addresses 0..tap_count, pairs
// every returned word with its tap index and first/last flags, and streams the
// bundles to the MAC array through a small FIFO that absorbs the 1-cycle RAM
// latency, so MAC backpressure never loses data.
//
// Optional feature macro: FIR_COEFF_BANK_SWAP_EN (double-buffered coefficient
// banks selected by the address MSB).
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   sample_valid_i/ready_o: frame start handshake (ready only in IDLE)
//   tap_count_i           : taps minus one, latched at frame start
//   coeff_en_o/addr_o     : RAM port-b read enable / address
//   coeff_data_i          : RAM port-b data, valid the cycle after coeff_en_o
//   tap_valid_o/ready_i   : tap bundle stream handshake
//   tap_coeff_o/idx_o     : coefficient and its tap index
//   tap_first_o/last_o    : first / last tap of the frame
//   frame_done_o          : pulse when the last tap is accepted
//   busy_o                : frame in progress
//   bank_swap_req_i       : request a coefficient bank swap (bank feature)
//   active_bank_o         : current coefficient bank (bank feature)
//
// state | meaning
// IDLE  | waiting for a sample; sample_ready_o high
// RUN   | issuing one coefficient read per cycle while the FIFO has credit
// DRAIN | all reads issued; waiting for the last bundle to be accepted
module student_fir_coeff_sequencer
  import student_fir_pkg::*;
#(
  parameter int AddrWidth     = 10,
  parameter int CoeffDataSize = 16,
  parameter int FifoDepth     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  output logic                     sample_ready_o,
  input  logic [AddrWidth-1:0]     tap_count_i,
  output logic                     coeff_en_o,
  output logic [AddrWidth-1:0]     coeff_addr_o,
  input  logic [CoeffDataSize-1:0] coeff_data_i,
  output logic                     tap_valid_o,
  input  logic                     tap_ready_i,
  output logic [CoeffDataSize-1:0] tap_coeff_o,
  output logic [AddrWidth-1:0]     tap_idx_o,
  output logic                     tap_first_o,
  output logic                     tap_last_o,
  output logic                     frame_done_o,
  output logic                     busy_o,
  input  logic                     bank_swap_req_i,
  output logic                     active_bank_o
);

  // A FIFO shallower than the minimum would only throttle throughput, so it
  // is quietly raised to the minimum.
  localparam int EffDepth = (FifoDepth < MinFifoDepth) ? MinFifoDepth : FifoDepth;
  localparam int CntW     = $clog2(EffDepth + 1);
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(EffDepth);

  typedef struct packed {
    logic [CoeffDataSize-1:0] coeff;
    logic [AddrWidth-1:0]     idx;
    logic                     first;
    logic                     last;
  } bundle_t;

  coeff_seq_state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] tap_count_q;
  logic [AddrWidth-1:0] tap_count_eff;
  logic [AddrWidth-1:0] idx_q;
  logic                 en_q;
  logic                 last_q;

  logic                 accept;
  logic                 issue;
  logic                 issue_last;
  logic                 room;
  logic [CntW:0]        need;

  bundle_t              push_bundle;
  bundle_t              head;
  logic [CntW-1:0]      fifo_occ;
  logic                 fifo_empty;
  logic                 unused_fifo_full;
  logic                 pop;
  logic                 frame_done;

  // Credit: entries stored + read in flight + this read must fit. A pop in
  // the same cycle is deliberately not credited, keeping the check registered-only.
  assign need       = {1'b0, fifo_occ} + {{CntW{1'b0}}, en_q} + (CntW + 1)'(1);
  assign room       = (need <= DepthCnt);
  assign issue_last = (addr_q == tap_count_q);

  always_comb begin
    state_d        = state_q;
    sample_ready_o = 1'b0;
    busy_o         = 1'b1;
    issue          = 1'b0;
    accept         = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready_o = 1'b1;
        busy_o         = 1'b0;
        if (sample_valid_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        issue = room;
        if (room && issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      tap_count_q <= '0;
      idx_q       <= '0;
      en_q        <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      en_q <= issue;
      if (accept) begin
        addr_q      <= '0;
        tap_count_q <= tap_count_eff;
      end
      if (issue) begin
        idx_q  <= addr_q;
        last_q <= issue_last;
        // The final address is held rather than incremented so it never wraps.
        if (!issue_last) begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign push_bundle.coeff = coeff_data_i;
  assign push_bundle.idx   = idx_q;
  assign push_bundle.first = (idx_q == '0);
  assign push_bundle.last  = last_q;

  student_sync_fifo #(
    .entry_t (bundle_t),
    .Depth   (EffDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (en_q),
    .push_data_i (push_bundle),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (fifo_occ),
    .empty_o     (fifo_empty),
    .full_o      (unused_fifo_full)
  );

  assign tap_valid_o  = !fifo_empty;
  assign pop          = tap_valid_o && tap_ready_i;
  assign frame_done   = (state_q == DRAIN) && pop && head.last;
  assign frame_done_o = frame_done;

  // Stale FIFO storage is masked so idle outputs read as zero.
  assign tap_coeff_o  = tap_valid_o ? head.coeff : '0;
  assign tap_idx_o    = tap_valid_o ? head.idx   : '0;
  assign tap_first_o  = tap_valid_o && head.first;
  assign tap_last_o   = tap_valid_o && head.last;
  assign coeff_en_o   = issue;

`ifdef FIR_COEFF_BANK_SWAP_EN
  logic bank_q;
  logic pending_q;
  logic swap_now;
  logic unused_count_msb;

  // Swaps only happen at a frame boundary so a frame never mixes banks.
  assign swap_now = pending_q && (frame_done || (state_q == IDLE));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q    <= 1'b0;
      pending_q <= 1'b0;
    end else if (swap_now) begin
      bank_q    <= ~bank_q;
      pending_q <= bank_swap_req_i;
    end else if (bank_swap_req_i) begin
      pending_q <= 1'b1;
    end
  end

  assign unused_count_msb = tap_count_i[AddrWidth-1];
  assign tap_count_eff    = {1'b0, tap_count_i[AddrWidth-2:0]};
  assign coeff_addr_o     = {bank_q, addr_q[AddrWidth-2:0]};
  assign active_bank_o    = bank_q;
`else
  logic unused_bank_req;

  assign unused_bank_req = bank_swap_req_i;
  assign tap_count_eff   = tap_count_i;
  assign coeff_addr_o    = addr_q;
  assign active_bank_o   = 1'b0;
`endif

endmodule
